step_rate_controller: RTL and testbench

Run/stop/single-step sequencer for the simple processor.
- Consumes the 1 Hz / 10 Hz / 100 Hz square waves from the board clock divider as data inputs.
- Emits a one-cycle clock enable (cpu_en) in the 50 MHz domain at the selected rate, or once per step-button press.
- Sits between the clock divider, the board push-buttons and the processor core; the processor runs on clock_in_50M gated by cpu_en.

---
 rtl/step_rate_controller.sv | 154 +++++++++++++++
 tb/tb_step_rate_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/step_rate_controller.sv
// Run/stop/single-step sequencer: emits a registered one-cycle cpu_en at the selected divided rate or per step press.
// Optional macro STEP_RATE_FULL_SPEED_EN: rate_sel=11 in RUN asserts cpu_en every cycle.
module step_rate_controller #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int COUNT_W         = 16
) (
   input  logic               clock_in_50M,
   input  logic               reset,
   input  logic               clock_1H,
   input  logic               clock_10H,
   input  logic               clock_100H,
   input  logic [1:0]         rate_sel,
   input  logic               run_btn,
   input  logic               step_btn,
   input  logic               halt,
   output logic               cpu_en,
   output logic               running,
   output logic               halted,
   output logic [COUNT_W-1:0] pulse_count
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_STOPPED = 2'd0,
      ST_RUN     = 2'd1,
      ST_STEP    = 2'd2,
      ST_HALTED  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         src_s1_q, src_s2_q, src_prev_q, src_rise;
   logic               sel_tick, full_speed;
   logic [1:0]         btn_s1_q, btn_s2_q;
   logic [1:0]         btn_acc_q, btn_acc_d;
   logic [1:0]         press_q, press_d;
   logic [DB_W-1:0]    db_cnt_q [2];
   logic [DB_W-1:0]    db_cnt_d [2];
   logic               cpu_en_q, cpu_en_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               run_press, step_press;

   // Edges are detected on every source all the time so a rate_sel change cannot fabricate one.
   assign src_rise = src_s2_q & ~src_prev_q;

   always_comb begin
      sel_tick = src_rise[2];
      case (rate_sel)
         2'b00:   sel_tick = src_rise[0];
         2'b01:   sel_tick = src_rise[1];
         default: sel_tick = src_rise[2];
      endcase
   end

`ifdef STEP_RATE_FULL_SPEED_EN
   assign full_speed = (rate_sel == 2'b11);
`else
   assign full_speed = 1'b0;
`endif

   // Index 0 = run button, index 1 = step button.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         btn_acc_d[i] = btn_acc_q[i];
         db_cnt_d[i]  = '0;
         press_d[i]   = 1'b0;
         if (btn_s2_q[i] != btn_acc_q[i]) begin
            if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               btn_acc_d[i] = btn_s2_q[i];
               press_d[i]   = btn_s2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   assign run_press  = press_q[0];
   assign step_press = press_q[1];

   always_comb begin
      state_d  = state_q;
      cpu_en_d = 1'b0;
      case (state_q)
         ST_STOPPED: begin
            if (halt) begin
               state_d = ST_HALTED;
            end else if (run_press) begin
               state_d = ST_RUN;
            end else if (step_press) begin
               state_d  = ST_STEP;
               cpu_en_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (halt) begin
               state_d = ST_HALTED;
            end else if (run_press) begin
               state_d = ST_STOPPED;
            end else begin
               cpu_en_d = sel_tick | full_speed;
            end
         end
         ST_STEP: begin
            state_d = halt ? ST_HALTED : ST_STOPPED;
         end
         ST_HALTED: begin
            if (run_press && !halt) begin
               state_d = ST_STOPPED;
            end
         end
         default: state_d = ST_STOPPED;
      endcase
   end

   // Count is loaded on the same edge as cpu_en so it always includes the visible pulse.
   assign count_d = count_q + {{(COUNT_W-1){1'b0}}, cpu_en_d};

   always_ff @(posedge clock_in_50M) begin
      if (reset) begin
         state_q    <= ST_STOPPED;
         src_s1_q   <= '0;
         src_s2_q   <= '0;
         src_prev_q <= '0;
         btn_s1_q   <= '0;
         btn_s2_q   <= '0;
         btn_acc_q  <= '0;
         press_q    <= '0;
         db_cnt_q[0] <= '0;
         db_cnt_q[1] <= '0;
         cpu_en_q   <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         src_s1_q   <= {clock_100H, clock_10H, clock_1H};
         src_s2_q   <= src_s1_q;
         src_prev_q <= src_s2_q;
         btn_s1_q   <= {step_btn, run_btn};
         btn_s2_q   <= btn_s1_q;
         btn_acc_q  <= btn_acc_d;
         press_q    <= press_d;
         db_cnt_q[0] <= db_cnt_d[0];
         db_cnt_q[1] <= db_cnt_d[1];
         cpu_en_q   <= cpu_en_d;
         count_q    <= count_d;
      end
   end

   assign cpu_en      = cpu_en_q;
   assign running     = (state_q == ST_RUN);
   assign halted      = (state_q == ST_HALTED);
   assign pulse_count = count_q;

endmodule

// File: tb/tb_step_rate_controller.sv
// Directed bench for step_rate_controller with DEBOUNCE_CYCLES=4 and COUNT_W=4.
module tb_step_rate_controller;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset, clk1, clk10, clk100, run_btn, step_btn, halt;
   logic [1:0]    rate_sel;
   logic          cpu_en, running, halted;
   logic [CW-1:0] pulse_count;

   int n_checks = 0;
   int n_errors = 0;
   int en_cnt = 0, run_len = 0, max_run = 0, b2b = 0;
   int e0;

   step_rate_controller #(.DEBOUNCE_CYCLES(4), .COUNT_W(CW)) dut (
      .clock_in_50M(clk),
      .reset(reset),
      .clock_1H(clk1),
      .clock_10H(clk10),
      .clock_100H(clk100),
      .rate_sel(rate_sel),
      .run_btn(run_btn),
      .step_btn(step_btn),
      .halt(halt),
      .cpu_en(cpu_en),
      .running(running),
      .halted(halted),
      .pulse_count(pulse_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cpu_en === 1'b1) begin
         en_cnt++;
         run_len++;
         if (run_len > max_run) max_run = run_len;
         if (run_len > 1) b2b++;
      end else begin
         run_len = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clk1 = 1'b0; clk10 = 1'b0; clk100 = 1'b0;
      run_btn = 1'b0; step_btn = 1'b0; halt = 1'b0; rate_sel = 2'b00;
      cyc(3);
      reset = 1'b0;
      cyc(1);
   endtask

   task automatic press(input logic r, input logic s);
      run_btn = r; step_btn = s;
      cyc(10);
      run_btn = 1'b0; step_btn = 1'b0;
      cyc(10);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, then 10 Hz run with exact latency per rising edge.
      do_reset();
      check("rst cpu_en", cpu_en, 0);
      check("rst running", running, 0);
      check("rst halted", halted, 0);
      check("rst count", pulse_count, 0);
      rate_sel = 2'b01;
      press(1'b1, 1'b0);
      check("t1 running", running, 1);
      e0 = en_cnt;
      for (int p = 0; p < 3; p++) begin
         clk10 = 1'b1;
         cyc(1); check("t1 lat1", cpu_en, 0);
         cyc(1); check("t1 lat2", cpu_en, 0);
         cyc(1); check("t1 lat3", cpu_en, 1);
         cyc(1); check("t1 width", cpu_en, 0);
         cyc(4);
         clk10 = 1'b0;
         cyc(8);
      end
      check("t1 pulses", en_cnt - e0, 3);
      check("t1 count", pulse_count, 3);

      // Bouncy step press, then simultaneous run+step.
      do_reset();
      e0 = en_cnt;
      step_btn = 1'b1; cyc(1);
      step_btn = 1'b0; cyc(1);
      step_btn = 1'b1; cyc(10);
      step_btn = 1'b0; cyc(10);
      check("t2 step pulses", en_cnt - e0, 1);
      check("t2 count", pulse_count, 1);
      check("t2 stopped", running, 0);
      check("t2 not halted", halted, 0);
      press(1'b1, 1'b1);
      check("t2 both running", running, 1);
      check("t2 both no step", en_cnt - e0, 1);
      check("t2 both count", pulse_count, 1);

      // Rate switch 100 Hz -> 1 Hz while clock_100H is high.
      do_reset();
      rate_sel = 2'b10;
      press(1'b1, 1'b0);
      e0 = en_cnt;
      clk100 = 1'b1; cyc(6);
      check("t3 100Hz tick", en_cnt - e0, 1);
      rate_sel = 2'b00;
      cyc(6);
      clk100 = 1'b0; cyc(4);
      clk100 = 1'b1; cyc(6);
      check("t3 no tick after switch", en_cnt - e0, 1);
      clk1 = 1'b1;
      cyc(2); check("t3 1Hz early", cpu_en, 0);
      cyc(1); check("t3 1Hz tick", cpu_en, 1);
      cyc(3);
      check("t3 total", en_cnt - e0, 2);

      // Halt coinciding with a synchronized tick.
      do_reset();
      rate_sel = 2'b01;
      press(1'b1, 1'b0);
      e0 = en_cnt;
      clk10 = 1'b1;
      cyc(2);
      halt = 1'b1;
      cyc(1);
      check("t4 tick masked", cpu_en, 0);
      check("t4 halted", halted, 1);
      check("t4 not running", running, 0);
      cyc(5);
      check("t4 no pulses", en_cnt - e0, 0);
      press(1'b1, 1'b0);
      check("t4 run w/ halt ignored", halted, 1);
      halt = 1'b0;
      cyc(3);
      check("t4 halt drop alone", halted, 1);
      press(1'b1, 1'b0);
      check("t4 unhalted", halted, 0);
      check("t4 stopped", running, 0);
      clk10 = 1'b0;

      // Counter wrap at 2^COUNT_W.
      do_reset();
      e0 = en_cnt;
      for (int k = 0; k < 15; k++) press(1'b0, 1'b1);
      check("t5 count 15", pulse_count, 15);
      press(1'b0, 1'b1);
      check("t5 wrap", pulse_count, 0);
      check("t5 pulses", en_cnt - e0, 16);
      check("no back-to-back", b2b, 0);

      // rate_sel=11 for 20 cycles in RUN.
      do_reset();
      press(1'b1, 1'b0);
      check("t6 running", running, 1);
      e0 = en_cnt;
      max_run = 0;
      rate_sel = 2'b11;
      for (int k = 0; k < 20; k++) begin
         clk100 = ((k % 8) < 4);
         cyc(1);
      end
      rate_sel = 2'b00;
      clk100 = 1'b0;
      cyc(4);
`ifdef STEP_RATE_FULL_SPEED_EN
      check("t6 pulses", en_cnt - e0, 20);
      check("t6 max run", max_run, 20);
      check("t6 count", pulse_count, 20 % (1 << CW));
`else
      check("t6 pulses", en_cnt - e0, 3);
      check("t6 max run", max_run, 1);
      check("t6 count", pulse_count, 3);
`endif

      // Reset while a pulse is high.
      do_reset();
      rate_sel = 2'b01;
      press(1'b1, 1'b0);
      clk10 = 1'b1;
      cyc(3);
      check("t7 pulse high", cpu_en, 1);
      reset = 1'b1;
      cyc(1);
      check("t7 cpu_en cleared", cpu_en, 0);
      check("t7 running cleared", running, 0);
      check("t7 count cleared", pulse_count, 0);
      reset = 1'b0;
      cyc(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
